// File: rtl/md5_search_scheduler.sv
// Brute-force MD5 search scheduler: hands candidate ranges to N external
// hash pipes, compares returned digests and reports the first hit.
module md5_search_scheduler #(
  parameter int N_PIPES = 2,
  parameter int CAND_W  = 32,
  parameter int CNT_W   = 48
) (
  input  logic                      CLK,
  input  logic                      CPU_RESET,
  input  logic                      start,
  input  logic                      enable,
  input  logic [CAND_W-1:0]         range_start,
  input  logic [CAND_W-1:0]         range_end,
  input  logic [127:0]              target_digest,
  output logic [N_PIPES-1:0]        pipe_valid,
  output logic [N_PIPES*CAND_W-1:0] pipe_cand,
  input  logic [N_PIPES-1:0]        res_valid,
  input  logic [N_PIPES*CAND_W-1:0] res_cand,
  input  logic [N_PIPES*128-1:0]    res_digest,
  output logic                      status_idle,
  output logic                      status_warming,
  output logic                      status_running,
  output logic                      status_paused,
  output logic                      status_drain,
  output logic                      status_found,
  output logic                      status_done,
  output logic [CAND_W-1:0]         found_cand,
  output logic [CNT_W-1:0]          checked
);

  localparam int IF_W = $clog2(N_PIPES * 1024) + 1;
  localparam int NW   = CAND_W + 1;
  localparam int CW1  = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WARM, S_RUN, S_PAUSE, S_DRAIN, S_FOUND, S_DONE
  } state_t;

  state_t             state;
  logic [NW-1:0]      nxt;
  logic [CAND_W-1:0]  r_end;
  logic [127:0]       target;
  logic               got_res;
  logic [IF_W-1:0]    inflight;

  logic               active;
  logic               match;
  logic [CAND_W-1:0]  match_cand;
  logic [IF_W-1:0]    pv_cnt;
  logic [IF_W-1:0]    rv_cnt;
  logic [IF_W-1:0]    inflight_nx;
  logic [CW1-1:0]     chk_sum;
  logic               exhausted;
  logic               issuing;

  always_comb begin
    active = (state == S_WARM) || (state == S_RUN) ||
             (state == S_PAUSE) || (state == S_DRAIN);
    match      = 1'b0;
    match_cand = '0;
    pv_cnt     = '0;
    rv_cnt     = '0;
    // descending scan so the lowest matching pipe wins
    for (int i = N_PIPES - 1; i >= 0; i--) begin
      if (res_valid[i] && res_digest[i*128 +: 128] == target) begin
        match      = 1'b1;
        match_cand = res_cand[i*CAND_W +: CAND_W];
      end
    end
    for (int i = 0; i < N_PIPES; i++) begin
      pv_cnt = pv_cnt + IF_W'(pipe_valid[i]);
      rv_cnt = rv_cnt + IF_W'(res_valid[i]);
    end
    inflight_nx = inflight + pv_cnt - rv_cnt;
    chk_sum     = {1'b0, checked} + CW1'(rv_cnt);
    exhausted   = nxt > {1'b0, r_end};
    issuing     = ((state == S_WARM) || (state == S_RUN)) &&
                  enable && !match && !exhausted;
  end

  always_ff @(posedge CLK) begin
    if (CPU_RESET) begin
      state      <= S_IDLE;
      nxt        <= '0;
      r_end      <= '0;
      target     <= '0;
      got_res    <= 1'b0;
      inflight   <= '0;
      pipe_valid <= '0;
      pipe_cand  <= '0;
      found_cand <= '0;
      checked    <= '0;
    end else begin
      pipe_valid <= '0;
      if (issuing) begin
        for (int i = 0; i < N_PIPES; i++) begin
          pipe_cand[i*CAND_W +: CAND_W] <= nxt[CAND_W-1:0] + CAND_W'(i);
          pipe_valid[i] <= (nxt + NW'(i)) <= {1'b0, r_end};
        end
        nxt <= nxt + NW'(N_PIPES);
      end
      if (active) begin
        inflight <= inflight_nx;
        checked  <= chk_sum[CNT_W] ? '1 : chk_sum[CNT_W-1:0];
        if (|res_valid) got_res <= 1'b1;
      end
      unique case (state)
        S_IDLE, S_FOUND, S_DONE: begin
          if (start) begin
            nxt        <= {1'b0, range_start};
            r_end      <= range_end;
            target     <= target_digest;
            found_cand <= '0;
            checked    <= '0;
            inflight   <= '0;
            got_res    <= 1'b0;
            state      <= S_WARM;
          end
        end
        S_WARM, S_RUN: begin
          if (match) begin
            found_cand <= match_cand;
            state      <= S_FOUND;
          end else if (exhausted) begin
            state <= (inflight_nx == '0) ? S_DONE : S_DRAIN;
          end else if (!enable) begin
            state <= S_PAUSE;
          end else if (state == S_WARM && |res_valid) begin
            state <= S_RUN;
          end
        end
        S_PAUSE: begin
          if (match) begin
            found_cand <= match_cand;
            state      <= S_FOUND;
          end else if (enable) begin
            state <= (got_res || |res_valid) ? S_RUN : S_WARM;
          end
        end
        S_DRAIN: begin
          if (match) begin
            found_cand <= match_cand;
            state      <= S_FOUND;
          end else if (inflight_nx == '0) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign status_idle    = state == S_IDLE;
  assign status_warming = state == S_WARM;
  assign status_running = state == S_RUN;
  assign status_paused  = state == S_PAUSE;
  assign status_drain   = state == S_DRAIN;
  assign status_found   = state == S_FOUND;
  assign status_done    = state == S_DONE;

endmodule
